shift_unit_pipelined: RTL and testbench
=======================================

# shift_unit_pipelined

Parametrised, pipelined shifter for N-bit operands. It performs logical-left, logical-right, arithmetic-right or rotate-right shifts in log2(N) register stages, using a valid/ready handshake with full backpressure. It sits between the ALU operand-select logic and the writeback mux. It replaces the single-mode combinational shifters, and sustains one result per cycle when the consumer is ready.

## Interface
- N, default 32: operand width. Must be a power of 2, with N ≥ 4.
- L, derived, equal to $clog2(N): pipeline depth, and the number of shamt bits used.
- clk  input  1: clock; all state updates on the rising edge.
- rst  input  1: synchronous, active-high reset.
- in_valid  input  1: the request beat is present.
- in_ready  output  1: the unit accepts the beat this cycle.
- in_data  input  N: operand.
- in_shamt  input  N: shift amount. Only bits [L-1:0] are used; upper bits are ignored, as in RISC-V.
- in_mode  input  2: shift_mode_t. SLL=0, SRL=1, SRA=2, ROR=3.
- out_valid  output  1: a result is present.
- out_ready  input  1: the consumer accepts the result.
- out_data  output  N: shifted result.

## Operation
- A beat transfers on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
- Stage k (k = 0..L-1) holds a registered slot containing: valid, data, mode, and shamt[L-1:k+1].
  - When shamt bit k of the entering beat is 1, the stage shifts by 2^k. When it is 0, data passes through unchanged.
- Per-mode shift rules:
  - SLL: zero-fill from the LSB side.
  - SRL: zero-fill from the MSB side.
  - SRA: fill with the current data[N-1]. The sign is preserved at every stage, so the result equals in_data >>> shamt.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
- A shamt of 0 in any mode gives out_data == in_data.
- The last stage's slot drives out_valid and out_data directly; there is no extra output register.
- Flow control:
  - stage_ready[k] = !valid[k] || stage_ready[k+1].
  - stage_ready[L] = out_ready.
  - in_ready = stage_ready[0].
  - When stage_ready[k] is 1, slot k loads from stage k-1, or from the input when k = 0. The slot's valid becomes the upstream valid-and-transfer.
- Beats are never dropped, duplicated or reordered.
- out_data is held stable while out_valid && !out_ready.
- in_data, in_shamt and in_mode are ignored when in_valid is 0.
- Simultaneous events:
  - Full pipeline with out_ready = 1 and in_valid = 1: one beat leaves and one enters in the same cycle, and in_ready stays 1.
  - Full pipeline with out_ready = 0: in_ready = 0.

## Timing
- Latency: exactly L cycles from the input transfer to out_valid, when the pipeline is unstalled. For N = 32, L = 5.
- Throughput: 1 beat/cycle while out_ready = 1.
- Capacity: L beats in flight.
- The ready chain is combinational from out_ready to in_ready. This is accepted for L ≤ 6, and no skid buffer is required.
- Reset:
  - While rst = 1 at the clock edge, all valid bits clear and all data/mode/shamt slot fields clear to 0.
  - After reset, out_valid = 0 and out_data = 0. in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards every in-flight beat. No result for those beats ever appears.
- No output depends combinationally on in_data, in_shamt or in_mode.

## Structure
- shift_pkg holds:
  - typedef enum logic [1:0] shift_mode_t {SLL, SRL, SRA, ROR}.
  - A localparam function for L.
- Sub-module shift_stage, parametrised by N and STAGE. It contains:
  - the one-position-of-2^STAGE shift/rotate mux for all four modes;
  - the slot registers;
  - the local ready logic.
- The top level is a generate loop of L shift_stage instances plus the port wiring.

## Test plan
- Mode check with N = 32, out_ready held at 1:
  - SLL 0x00000001 by 31 -> 0x80000000.
  - SRL 0x80000000 by 4 -> 0x08000000.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SRA 0x7FFFFFFF by 31 -> 0x00000000.
  - ROR 0x00000001 by 1 -> 0x80000000.
  - Each result appears exactly 5 cycles after acceptance.
- shamt masking: SRL 0xF0000000 with shamt 0x00000021 -> 0x78000000. shamt 0 in all four modes returns the input unchanged.
- Streaming: 64 back-to-back random beats with out_ready = 1.
  - in_ready stays 1 throughout.
  - Results arrive in order, one per cycle, and match a reference model.
- Backpressure: out_ready = 0 while 7 beats are offered.
  - Exactly 5 are accepted, then in_ready = 0.
  - out_data holds the first result stable.
  - Releasing out_ready drains all 5 in order, then accepts the remaining 2.
- Random stall: random in_valid and out_ready (50%) over 1000 beats produces no loss, duplication or reordering.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight.
  - Next cycle: out_valid = 0 and out_data = 0.
  - None of the 3 beats ever appears on the output.
  - A new beat issued afterwards emerges after 5 cycles with the correct value.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and helpers for the pipelined shifter: shift mode encoding and
// the pipeline-depth function used to size stages and shift-amount fields.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'd0,
    SRL = 2'd1,
    SRA = 2'd2,
    ROR = 2'd3
  } shift_mode_t;

  // Number of pipeline stages, and of shift-amount bits consumed, for width n.
  function automatic int shift_levels(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the shifter: conditionally shifts/rotates by 2**STAGE,
// holds the result in a registered slot and computes its local ready.
module shift_stage
  import shift_pkg::*;
#(
  parameter int N     = 32,
  parameter int STAGE = 0,
  localparam int L    = shift_levels(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid_i,
  input  logic [N-1:0] up_data_i,
  input  logic [1:0]   up_mode_i,
  input  logic [L-1:0] up_shamt_i,
  output logic         up_ready_o,
  input  logic         dn_ready_i,
  output logic         valid_o,
  output logic [N-1:0] data_o,
  output logic [1:0]   mode_o,
  output logic [L-1:0] shamt_o
);

  localparam int SH = 1 << STAGE;
  // Shift-amount bits at or below this stage are spent once this stage acts.
  localparam logic [L-1:0] KEEP_MASK = {L{1'b1}} << (STAGE + 1);

  shift_mode_t  mode;
  logic [N-1:0] shifted;
  logic [N-1:0] stage_out;

  logic         valid_q, valid_d;
  logic [N-1:0] data_q,  data_d;
  logic [1:0]   mode_q,  mode_d;
  logic [L-1:0] shamt_q, shamt_d;

  assign mode = shift_mode_t'(up_mode_i);

  always_comb begin
    shifted = up_data_i;
    unique case (mode)
      SLL: shifted = up_data_i << SH;
      SRL: shifted = up_data_i >> SH;
      SRA: shifted = $signed(up_data_i) >>> SH;
      ROR: shifted = (up_data_i >> SH) | (up_data_i << (N - SH));
      default: shifted = up_data_i;
    endcase
  end

  assign stage_out  = up_shamt_i[STAGE] ? shifted : up_data_i;
  assign up_ready_o = !valid_q || dn_ready_i;

  // NOTE: every next-state signal is given its hold value first, so no path
  // through this block leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    mode_d  = mode_q;
    shamt_d = shamt_q;
    if (up_ready_o) begin
      valid_d = up_valid_i;
      // Payload only moves with a real beat, keeping idle inputs out of the slot.
      if (up_valid_i) begin
        data_d  = stage_out;
        mode_d  = up_mode_i;
        shamt_d = up_shamt_i & KEEP_MASK;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every stage samples
  // its neighbour's pre-edge value and the pipeline advances one slot per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= '0;
      shamt_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      shamt_q <= shamt_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign mode_o  = mode_q;
  assign shamt_o = shamt_q;

endmodule

// File: rtl/shift_unit_pipelined.sv
// Pipelined N-bit shifter (SLL/SRL/SRA/ROR) built as a chain of log2(N)
// shift_stage slots with a combinational ready chain from out_ready to in_ready.
module shift_unit_pipelined
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [N-1:0] in_shamt,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  localparam int L = shift_levels(N);

  if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_width
    $error("shift_unit_pipelined: N must be a power of two and at least 4");
  end

  for (genvar k = 0; k < L; k++) begin : g_stage
    logic         up_valid;
    logic [N-1:0] up_data;
    logic [1:0]   up_mode;
    logic [L-1:0] up_shamt;
    logic         up_ready;
    logic         dn_ready;
    logic         valid;
    logic [N-1:0] data;
    logic [1:0]   mode;
    logic [L-1:0] shamt;

    if (k == 0) begin : g_head
      // Upper shift-amount bits are ignored, matching RISC-V shift semantics.
      assign up_valid = in_valid;
      assign up_data  = in_data;
      assign up_mode  = in_mode;
      assign up_shamt = in_shamt[L-1:0];
    end else begin : g_link
      assign up_valid = g_stage[k-1].valid;
      assign up_data  = g_stage[k-1].data;
      assign up_mode  = g_stage[k-1].mode;
      assign up_shamt = g_stage[k-1].shamt;
    end

    if (k == L - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = g_stage[k+1].up_ready;
    end

    shift_stage #(
      .N     (N),
      .STAGE (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid_i (up_valid),
      .up_data_i  (up_data),
      .up_mode_i  (up_mode),
      .up_shamt_i (up_shamt),
      .up_ready_o (up_ready),
      .dn_ready_i (dn_ready),
      .valid_o    (valid),
      .data_o     (data),
      .mode_o     (mode),
      .shamt_o    (shamt)
    );
  end

  assign in_ready  = g_stage[0].up_ready;
  assign out_valid = g_stage[L-1].valid;
  assign out_data  = g_stage[L-1].data;

  // The last slot's mode and (fully spent) shift amount have no consumer.
  logic unused_bits;
  assign unused_bits = ^{in_shamt[N-1:L], g_stage[L-1].shamt, g_stage[L-1].mode};

endmodule

// File: tb/tb_shift_unit_pipelined.sv
// Scoreboard bench for shift_unit_pipelined: a driver pushes expected results
// from a bit-level reference model, a monitor pops and compares on each output.
module tb_shift_unit_pipelined;
  import shift_pkg::*;

  localparam int N = 32;
  localparam int L = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [N-1:0] in_shamt;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  shift_unit_pipelined #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] data;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   stream_chk = 0;
  bit   rand_stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_stall) out_ready = 1'($urandom_range(0, 1));
  end

  // Result defined bit by bit from where each output bit comes from.
  function automatic logic [N-1:0] ref_model(input logic [N-1:0] d, input logic [N-1:0] s,
                                             input logic [1:0] m);
    int amt;
    logic [N-1:0] r;
    amt = int'(s % N);
    for (int i = 0; i < N; i++) begin
      case (m)
        2'd0:    r[i] = (i >= amt) ? d[i-amt] : 1'b0;
        2'd1:    r[i] = (i + amt < N) ? d[i+amt] : 1'b0;
        2'd2:    r[i] = (i + amt < N) ? d[i+amt] : d[N-1];
        default: r[i] = d[(i+amt)%N];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got 0x%08h, required no output (t=%0t)", out_data, $time);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        check("result", out_data, e.data);
        if (e.lat) check("latency", N'(cyc - e.cyc), N'(L));
      end else begin
        check("stall_hold", out_data, exp_q[0].data);
      end
    end
  end

  task automatic send(input logic [N-1:0] d, input logic [N-1:0] s, input logic [1:0] m,
                      input logic [N-1:0] e, input bit lat);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
    @(negedge clk);
    if (stream_chk) check("stream_in_ready", {31'b0, in_ready}, 32'd1);
    while (!in_ready && waited < 500) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      waited++;
    end
    if (in_ready) begin
      exp_q.push_back('{data: e, cyc: cyc, lat: lat});
    end else begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stuck at 0, required 1 within 500 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat);
    logic [N-1:0] d;
    logic [N-1:0] s;
    logic [1:0]   m;
    d = $urandom;
    s = $urandom;
    m = 2'($urandom_range(0, 3));
    send(d, s, m, ref_model(d, s, m), lat);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", N'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: time limit reached, required test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] bp_d [7];
    logic [N-1:0] bp_s [7];
    logic [1:0]   bp_m [7];
    logic [N-1:0] z;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed mode and shift-amount masking cases.
    send(32'h0000_0001, 32'd31, SLL, 32'h8000_0000, 1'b1);
    send(32'h8000_0000, 32'd4,  SRL, 32'h0800_0000, 1'b1);
    send(32'h8000_0000, 32'd4,  SRA, 32'hF800_0000, 1'b1);
    send(32'h7FFF_FFFF, 32'd31, SRA, 32'h0000_0000, 1'b1);
    send(32'h0000_0001, 32'd1,  ROR, 32'h8000_0000, 1'b1);
    send(32'hF000_0000, 32'h21, SRL, 32'h7800_0000, 1'b1);
    z = 32'hA5C3_1E7F;
    for (int m = 0; m < 4; m++) send(z, 32'h0000_0040, 2'(m), z, 1'b1);
    wait_drain();

    // Back-to-back streaming.
    stream_chk = 1'b1;
    repeat (64) send_rand(1'b1);
    stream_chk = 1'b0;
    wait_drain();

    // Backpressure: fill with out_ready low, offer more, then release.
    for (int i = 0; i < 7; i++) begin
      bp_d[i] = $urandom;
      bp_s[i] = $urandom;
      bp_m[i] = 2'($urandom_range(0, 3));
    end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(bp_d[i], bp_s[i], bp_m[i], ref_model(bp_d[i], bp_s[i], bp_m[i]), 1'b0);
    in_valid = 1'b1; in_data = bp_d[5]; in_shamt = bp_s[5]; in_mode = bp_m[5];
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_first", out_data, ref_model(bp_d[0], bp_s[0], bp_m[0]));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 5; i < 7; i++) send(bp_d[i], bp_s[i], bp_m[i], ref_model(bp_d[i], bp_s[i], bp_m[i]), 1'b0);
    wait_drain();

    // Random input gaps and random consumer stalls.
    rand_stall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_rand(1'b0);
    end
    rand_stall = 1'b0;
    out_ready  = 1'b1;
    wait_drain();

    // Reset with three beats in flight; none of them may emerge.
    repeat (3) send_rand(1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_data", out_data, 32'h0);
    repeat (10) @(posedge clk);
    #1;
    send(32'h1234_5678, 32'd8, ROR, 32'h7812_3456, 1'b1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
